// File: rtl/fetch_unit.sv
// Program counter and instruction register stage for the mycpu datapath.
// Latches fetched words into the IR and steps the PC as the control unit selects.
module fetch_unit #(
    parameter int              DW       = 16,
    parameter logic [DW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          il_in,
    input  logic [1:0]    ps_in,
    input  logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] ra_in,
    output logic [DW-1:0] pc_out,
    output logic [DW-1:0] ins_out,
    output logic          ir_valid_out,
    output logic          pc_wrap_out
);

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ins_q, ins_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;

    logic [5:0]    off6;
    logic [DW-1:0] off;
    logic [DW:0]   inc_sum;
    logic [DW:0]   br_sum;
    logic          br_wrap;

    // Branch offset comes from the registered IR, so a same-edge load
    // never affects the branch target.
    always_comb begin
        off6    = {ins_q[8:6], ins_q[2:0]};
        off     = {{(DW-6){off6[5]}}, off6};
        inc_sum = {1'b0, pc_q} + {{DW{1'b0}}, 1'b1};
        br_sum  = {1'b0, pc_q} + {1'b0, off};
        // Positive offsets wrap on carry-out; negative ones wrap when
        // the sign-extended add fails to carry (a borrow).
        br_wrap = off6[5] ? ~br_sum[DW] : br_sum[DW];
    end

    // Next-state selection for PC, wrap flag and IR.
    always_comb begin
        pc_d    = pc_q;
        wrap_d  = 1'b0;
        ins_d   = ins_q;
        valid_d = valid_q;
        case (ps_in)
            PS_HOLD: pc_d = pc_q;
            PS_INC: begin
                pc_d   = inc_sum[DW-1:0];
                wrap_d = inc_sum[DW];
            end
            PS_BR: begin
                pc_d   = br_sum[DW-1:0];
                wrap_d = br_wrap;
            end
            PS_JMP:  pc_d = ra_in;
            default: pc_d = pc_q;
        endcase
        if (il_in) begin
            ins_d   = mem_data_in;
            valid_d = 1'b1;
        end
    end

    // State registers with asynchronous reset overriding all inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pc_out       = pc_q;
    assign ins_out      = ins_q;
    assign ir_valid_out = valid_q;
    assign pc_wrap_out  = wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: integer reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        il_in;
    logic [1:0]  ps_in;
    logic [15:0] mem_data_in;
    logic [15:0] ra_in;
    logic [15:0] pc_out;
    logic [15:0] ins_out;
    logic        ir_valid_out;
    logic        pc_wrap_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    int          m_pc;
    logic [15:0] m_ins;
    bit          m_valid;
    bit          m_wrap;

    fetch_unit #(.DW(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .il_in        (il_in),
        .ps_in        (ps_in),
        .mem_data_in  (mem_data_in),
        .ra_in        (ra_in),
        .pc_out       (pc_out),
        .ins_out      (ins_out),
        .ir_valid_out (ir_valid_out),
        .pc_wrap_out  (pc_wrap_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over the PC address space.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    = 0;
            m_ins   = 16'h0000;
            m_valid = 0;
            m_wrap  = 0;
        end else begin
            logic [5:0] f;
            int off;
            int np;
            bit w;
            f   = {m_ins[8:6], m_ins[2:0]};
            off = f[5] ? int'(f) - 64 : int'(f);
            np  = m_pc;
            w   = 0;
            case (ps_in)
                2'd1: np = m_pc + 1;
                2'd2: np = m_pc + off;
                2'd3: np = int'(ra_in);
                default: np = m_pc;
            endcase
            if (ps_in == 2'd1 || ps_in == 2'd2)
                w = (np < 0) || (np > 65535);
            m_pc   = np & 32'h0000FFFF;
            m_wrap = w;
            if (il_in) begin
                m_ins   = mem_data_in;
                m_valid = 1;
            end
        end
    end

    // Compare DUT against model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc", pc_out, 16'(m_pc));
            chk("model_ins", ins_out, m_ins);
            chk("model_valid", {15'd0, ir_valid_out}, {15'd0, m_valid});
            chk("model_wrap", {15'd0, pc_wrap_out}, {15'd0, m_wrap});
        end
    end

    task automatic cyc(input logic il, input logic [1:0] ps,
                       input logic [15:0] mem, input logic [15:0] ra);
        il_in       = il;
        ps_in       = ps;
        mem_data_in = mem;
        ra_in       = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        il_in = 0;
        ps_in = 2'b00;
        mem_data_in = 16'h0;
        ra_in = 16'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ins", ins_out, 16'h0000);
        chk("rst_valid", {15'd0, ir_valid_out}, 16'd0);
        chk("rst_wrap", {15'd0, pc_wrap_out}, 16'd0);
        #2 rst = 0;
        chk_en = 1;

        cyc(1, 2'b00, 16'h1234, 16'h0);
        chk("load_pc", pc_out, 16'h0000);
        chk("load_ins", ins_out, 16'h1234);
        chk("load_valid", {15'd0, ir_valid_out}, 16'd1);

        cyc(0, 2'b11, 16'h0, 16'h0005);
        chk("jmp5", pc_out, 16'h0005);
        cyc(0, 2'b01, 16'h0, 16'h0);
        chk("inc6", pc_out, 16'h0006);
        cyc(0, 2'b01, 16'h0, 16'h0);
        chk("inc7", pc_out, 16'h0007);
        cyc(0, 2'b01, 16'h0, 16'h0);
        chk("inc8", pc_out, 16'h0008);
        chk("inc_nowrap", {15'd0, pc_wrap_out}, 16'd0);
        cyc(0, 2'b00, 16'h0, 16'h0);
        chk("hold8", pc_out, 16'h0008);

        cyc(1, 2'b11, 16'h01C5, 16'h0010);
        chk("setup_ins", ins_out, 16'h01C5);
        cyc(0, 2'b10, 16'h0, 16'h0);
        chk("br_m3", pc_out, 16'h000D);
        cyc(1, 2'b11, 16'h00C7, 16'h0010);
        cyc(0, 2'b10, 16'h0, 16'h0);
        chk("br_p31", pc_out, 16'h002F);
        chk("br_nowrap", {15'd0, pc_wrap_out}, 16'd0);

        cyc(0, 2'b11, 16'h0, 16'hFFFF);
        chk("jmp_ffff", pc_out, 16'hFFFF);
        cyc(0, 2'b01, 16'h0, 16'h0);
        chk("inc_wrap_pc", pc_out, 16'h0000);
        chk("inc_wrap", {15'd0, pc_wrap_out}, 16'd1);
        cyc(0, 2'b00, 16'h0, 16'h0);
        chk("wrap_pulse_end", {15'd0, pc_wrap_out}, 16'd0);
        cyc(0, 2'b11, 16'h0, 16'hFFFF);
        chk("jmp_nowrap1", {15'd0, pc_wrap_out}, 16'd0);
        cyc(0, 2'b11, 16'h0, 16'h0000);
        chk("jmp_nowrap2", {15'd0, pc_wrap_out}, 16'd0);
        chk("jmp_zero", pc_out, 16'h0000);

        cyc(1, 2'b11, 16'h01C5, 16'h0002);
        cyc(0, 2'b10, 16'h0, 16'h0);
        chk("br_borrow_pc", pc_out, 16'hFFFF);
        chk("br_borrow", {15'd0, pc_wrap_out}, 16'd1);
        cyc(0, 2'b00, 16'h0, 16'h0);
        chk("br_pulse_end", {15'd0, pc_wrap_out}, 16'd0);

        cyc(1, 2'b11, 16'h0001, 16'h0020);
        cyc(1, 2'b10, 16'h0007, 16'h0);
        chk("simul_pc", pc_out, 16'h0021);
        chk("simul_ins", ins_out, 16'h0007);

        ps_in = 2'b11;
        ra_in = 16'hABCD;
        il_in = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_pc", pc_out, 16'h0000);
        chk("arst_ins", ins_out, 16'h0000);
        chk("arst_valid", {15'd0, ir_valid_out}, 16'd0);
        chk("arst_wrap", {15'd0, pc_wrap_out}, 16'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_pc", pc_out, 16'h0000);
        @(negedge clk);
        #1 rst = 0;
        cyc(0, 2'b11, 16'h0, 16'hABCD);
        chk("post_rst_jmp", pc_out, 16'hABCD);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
